// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, load alignment, load-response wait.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [4:0]       RdM,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic             FlushW,
    input  logic             MemRespValid,
    input  logic [XLEN-1:0]  MemRespData,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic             StallWB,
    output logic [CNT_W-1:0] InstretW
);

    localparam int unsigned SRC_W = 2;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned RD_W  = 5;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic [SRC_W-1:0]  result_src_q, result_src_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;

    logic              is_load;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;

    // Stall, write enable and MEM/WB capture; outputs gated low while reset is asserted
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        pc_plus4_d   = pc_plus4_q;

        is_load   = valid_q & (result_src_q == 2'b01);
        StallWB   = reset & is_load & ~MemRespValid;
        RegWriteW = reset & valid_q & reg_write_q & (rd_q != '0) & ~StallWB;

        case (state_q)
            S_RUN:   if (is_load && !MemRespValid) state_d = S_WAIT;
            S_WAIT:  if (MemRespValid)             state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        if (!StallWB) begin
            if (FlushW) begin
                valid_d = 1'b0;
            end else begin
                valid_d      = ValidM;
                reg_write_d  = RegWriteM;
                result_src_d = ResultSrcM;
                funct3_d     = Funct3M;
                rd_d         = RdM;
                alu_result_d = ALUResultM;
                pc_plus4_d   = PCPlus4M;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_RUN;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    // Load extraction from the response word using the low address bits
    always_comb begin
        ld_byte = MemRespData[7:0];
        case (alu_result_q[1:0])
            2'd0:    ld_byte = MemRespData[7:0];
            2'd1:    ld_byte = MemRespData[15:8];
            2'd2:    ld_byte = MemRespData[23:16];
            default: ld_byte = MemRespData[31:24];
        endcase
        ld_half = alu_result_q[1] ? MemRespData[31:16] : MemRespData[15:0];

        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = MemRespData;
        endcase
    end

    always_comb begin
        ResultW = '0;
        case (result_src_q)
            2'b00:   ResultW = alu_result_q;
            2'b01:   ResultW = ld_data;
            2'b10:   ResultW = pc_plus4_q;
            default: ResultW = '0;
        endcase
    end

    assign RdW = rd_q;

`ifdef WB_INSTRET_EN
    logic             retire;
    logic [CNT_W-1:0] instret_q, instret_d;

    // Every instruction leaving WB counts, including those that do not write rd
    always_comb begin
        retire    = valid_q & ~StallWB;
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (!reset) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign InstretW = instret_q;
`else
    assign InstretW = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors, corner sequences, randomized run vs model.
module tb_wb_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             ValidM, RegWriteM, FlushW, MemRespValid;
    logic [1:0]       ResultSrcM;
    logic [2:0]       Funct3M;
    logic [4:0]       RdM;
    logic [XLEN-1:0]  ALUResultM, PCPlus4M, MemRespData;
    logic             RegWriteW, StallWB;
    logic [4:0]       RdW;
    logic [XLEN-1:0]  ResultW;
    logic [CNT_W-1:0] InstretW;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .FlushW(FlushW),
        .MemRespValid(MemRespValid), .MemRespData(MemRespData),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallWB(StallWB), .InstretW(InstretW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        we;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        flush;
        logic        mrv;
        logic [31:0] mrd;
    } in_t;

    typedef struct {
        in_t         op;
        logic [31:0] data;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_res;
    } vec_t;

    // Model of the instruction sitting in WB plus the retired count
    typedef struct {
        logic        valid;
        logic        we;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
    } slot_t;

    int   checks = 0;
    int   errors = 0;
    in_t  cur;
    slot_t m;
    int   m_cnt = 0;
    bit   known = 0;

    function automatic in_t mk(logic rst, logic valid, logic we, logic [1:0] src,
                               logic [2:0] f3, logic [4:0] rd, logic [31:0] alu,
                               logic [31:0] pc, logic flush, logic mrv, logic [31:0] mrd);
        in_t x;
        x.rst = rst; x.valid = valid; x.we = we; x.src = src; x.f3 = f3; x.rd = rd;
        x.alu = alu; x.pc = pc; x.flush = flush; x.mrv = mrv; x.mrd = mrd;
        return x;
    endfunction

    function automatic in_t bubble();
        return mk(1, 0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 0, 0, 32'd0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load value computed from the byte/half arithmetic of the ISA
    function automatic logic [31:0] load_value(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) % 256;
        h = (off >= 2) ? (w >> 16) % 65536 : w % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? (32'hFFFFFF00 | b) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (32'hFFFF0000 | h) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic bit m_stall();
        return cur.rst && m.valid && m.src == 2'b01 && !cur.mrv;
    endfunction

    task automatic model_check();
        bit          stall, we;
        logic [31:0] res;
        stall = m_stall();
        we    = cur.rst && m.valid && m.we && m.rd != 0 && !stall;
        case (m.src)
            2'b00:   res = m.alu;
            2'b01:   res = load_value(m.f3, m.alu[1:0], cur.mrd);
            2'b10:   res = m.pc;
            default: res = 32'd0;
        endcase
        chk("mdl_stall", 64'(StallWB), 64'(stall));
        chk("mdl_we", 64'(RegWriteW), 64'(we));
        chk("mdl_instret", 64'(InstretW), 64'(m_cnt % (1 << CNT_W)));
        if (m.valid) begin
            chk("mdl_rd", 64'(RdW), 64'(m.rd));
            chk("mdl_result", 64'(ResultW), 64'(res));
        end
    endtask

    task automatic model_update();
        bit stall;
        if (!cur.rst) begin
            m = '{default: '0};
            m_cnt = 0;
            known = 1;
        end else begin
            stall = m_stall();
`ifdef WB_INSTRET_EN
            if (m.valid && !stall) m_cnt = (m_cnt + 1) % (1 << CNT_W);
`endif
            if (!stall) begin
                if (cur.flush) m.valid = 0;
                else begin
                    m.valid = cur.valid; m.we = cur.we; m.src = cur.src; m.f3 = cur.f3;
                    m.rd = cur.rd; m.alu = cur.alu; m.pc = cur.pc;
                end
            end
        end
    endtask

    task automatic drive(input in_t x);
        @(negedge clk);
        cur = x;
        reset = x.rst; ValidM = x.valid; RegWriteM = x.we; ResultSrcM = x.src;
        Funct3M = x.f3; RdM = x.rd; ALUResultM = x.alu; PCPlus4M = x.pc;
        FlushW = x.flush; MemRespValid = x.mrv; MemRespData = x.mrd;
        #1;
        if (known) model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        in_t x;
        x = bubble();
        x.rst = 0;
        drive(x);
        tick();
    endtask

    vec_t vecs[13];
    in_t  x;

    initial begin
        vecs[0]  = '{mk(1,1,1,2'b00,3'b000,5'd5,32'h1234,32'h0,0,0,0), 32'h0, 1, 5'd5, 32'h1234};
        vecs[1]  = '{mk(1,1,1,2'b10,3'b000,5'd1,32'h0,32'h104,0,0,0), 32'h0, 1, 5'd1, 32'h104};
        vecs[2]  = '{mk(1,1,1,2'b10,3'b000,5'd0,32'h0,32'h104,0,0,0), 32'h0, 0, 5'd0, 32'h104};
        vecs[3]  = '{mk(1,1,1,2'b01,3'b000,5'd7,32'h102,32'h0,0,0,0), 32'h00F30000, 1, 5'd7, 32'hFFFFFFF3};
        vecs[4]  = '{mk(1,1,1,2'b01,3'b100,5'd7,32'h102,32'h0,0,0,0), 32'h00F30000, 1, 5'd7, 32'h000000F3};
        vecs[5]  = '{mk(1,1,1,2'b01,3'b001,5'd8,32'h202,32'h0,0,0,0), 32'h80010000, 1, 5'd8, 32'hFFFF8001};
        vecs[6]  = '{mk(1,1,1,2'b01,3'b101,5'd8,32'h200,32'h0,0,0,0), 32'h1234F00F, 1, 5'd8, 32'h0000F00F};
        vecs[7]  = '{mk(1,1,1,2'b01,3'b010,5'd9,32'h300,32'h0,0,0,0), 32'hDEADBEEF, 1, 5'd9, 32'hDEADBEEF};
        vecs[8]  = '{mk(1,1,1,2'b11,3'b000,5'd3,32'h55,32'h99,0,0,0), 32'h0, 1, 5'd3, 32'h0};
        vecs[9]  = '{mk(1,1,0,2'b00,3'b000,5'd4,32'h77,32'h0,0,0,0), 32'h0, 0, 5'd4, 32'h77};
        vecs[10] = '{mk(1,1,1,2'b01,3'b000,5'd2,32'h3,32'h0,0,0,0), 32'h7F000000, 1, 5'd2, 32'h0000007F};
        vecs[11] = '{mk(1,1,1,2'b01,3'b011,5'd6,32'h1,32'h0,0,0,0), 32'hA5A5C3C3, 1, 5'd6, 32'hA5A5C3C3};
        vecs[12] = '{mk(1,1,1,2'b01,3'b100,5'd31,32'h1,32'h0,0,0,0), 32'h00008000, 1, 5'd31, 32'h00000080};

        cur = bubble();
        do_reset();

        // Reset state
        drive(bubble());
        chk("rst_we", 64'(RegWriteW), 64'd0);
        chk("rst_stall", 64'(StallWB), 64'd0);
        chk("rst_rd", 64'(RdW), 64'd0);
        chk("rst_result", 64'(ResultW), 64'd0);
        chk("rst_instret", 64'(InstretW), 64'd0);
        tick();

        // Directed vectors: op enters WB, response (if any) arrives the same cycle
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op);
            tick();
            x = bubble();
            x.mrv = (vecs[i].op.src == 2'b01);
            x.mrd = vecs[i].data;
            drive(x);
            chk($sformatf("vec%0d_we", i), 64'(RegWriteW), 64'(vecs[i].exp_we));
            chk($sformatf("vec%0d_rd", i), 64'(RdW), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_result", i), 64'(ResultW), 64'(vecs[i].exp_res));
            chk($sformatf("vec%0d_stall", i), 64'(StallWB), 64'd0);
            tick();
        end

        // Delayed LW: three stalled cycles with a flush and new MEM data ignored, then write
        drive(mk(1,1,1,2'b01,3'b010,5'd9,32'h100,32'h0,0,0,0));
        tick();
        for (int c = 0; c < 3; c++) begin
            x = mk(1,1,1,2'b00,3'b000,5'd3,32'hBAD,32'h0,(c == 1),0,32'h11111111);
            drive(x);
            chk($sformatf("wait%0d_stall", c), 64'(StallWB), 64'd1);
            chk($sformatf("wait%0d_we", c), 64'(RegWriteW), 64'd0);
            tick();
        end
        drive(mk(1,1,1,2'b00,3'b000,5'd3,32'hBAD,32'h0,0,1,32'hCAFEF00D));
        chk("dly_we", 64'(RegWriteW), 64'd1);
        chk("dly_rd", 64'(RdW), 64'd9);
        chk("dly_result", 64'(ResultW), 64'hCAFEF00D);
        chk("dly_stall", 64'(StallWB), 64'd0);
        tick();
        drive(bubble());
        chk("after_dly_rd", 64'(RdW), 64'd3);
        chk("after_dly_result", 64'(ResultW), 64'hBAD);
        tick();

        // Reset while waiting abandons the load; a late response is ignored
        drive(mk(1,1,1,2'b01,3'b010,5'd4,32'h40,32'h0,0,0,0));
        tick();
        drive(bubble());
        chk("rw_stall", 64'(StallWB), 64'd1);
        tick();
        x = bubble();
        x.rst = 0;
        drive(x);
        chk("rw_gate_stall", 64'(StallWB), 64'd0);
        chk("rw_gate_we", 64'(RegWriteW), 64'd0);
        tick();
        x = bubble();
        x.mrv = 1;
        x.mrd = 32'h12345678;
        drive(x);
        chk("rw_late_stall", 64'(StallWB), 64'd0);
        chk("rw_late_we", 64'(RegWriteW), 64'd0);
        tick();

        // Retire count: ALU, bubble, x0 write, JAL -> 3; then wrap through all-ones
        do_reset();
        drive(mk(1,1,1,2'b00,3'b000,5'd5,32'h1,32'h0,0,0,0)); tick();
        drive(bubble()); tick();
        drive(mk(1,1,1,2'b00,3'b000,5'd0,32'h2,32'h0,0,0,0)); tick();
        drive(mk(1,1,1,2'b10,3'b000,5'd1,32'h0,32'h104,0,0,0)); tick();
        drive(bubble()); tick();
        drive(bubble());
`ifdef WB_INSTRET_EN
        chk("instret_3", 64'(InstretW), 64'd3);
`else
        chk("instret_off", 64'(InstretW), 64'd0);
`endif
        tick();
        for (int i = 0; i < 252; i++) begin
            drive(mk(1,1,1,2'b00,3'b000,5'd7,32'(i),32'h0,0,0,0));
            tick();
        end
        drive(bubble()); tick();
        drive(bubble());
`ifdef WB_INSTRET_EN
        chk("instret_max", 64'(InstretW), 64'hFF);
`else
        chk("instret_off2", 64'(InstretW), 64'd0);
`endif
        tick();
        drive(mk(1,1,1,2'b00,3'b000,5'd7,32'h9,32'h0,0,0,0)); tick();
        drive(bubble()); tick();
        drive(bubble());
        chk("instret_wrap", 64'(InstretW), 64'd0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            x.rst   = ($urandom_range(0, 99) >= 2);
            x.valid = ($urandom_range(0, 9) < 8);
            x.we    = ($urandom_range(0, 9) < 8);
            x.src   = 2'($urandom_range(0, 3));
            x.f3    = 3'($urandom_range(0, 7));
            x.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            x.alu   = $urandom;
            x.pc    = $urandom;
            x.flush = ($urandom_range(0, 9) == 0);
            x.mrv   = ($urandom_range(0, 9) < 4);
            x.mrd   = $urandom;
            drive(x);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
